// File: rtl/display_scan_sched.sv
// Scan scheduler for a multiplexed seven-segment display: sequences digits with an
// on-time and an anti-ghosting blank gap, per-digit blinking and frame-aligned source select.
module display_scan_sched #(
  parameter int NUM_DIGITS  = 6,
  parameter int ON_TICKS    = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  enable,
  input  logic                  show_alarm,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic                  blink_toggle,
  output logic [2:0]            sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  src_alarm,
  output logic                  frame_start
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam logic [3:0]            ON_LAST    = 4'(ON_TICKS - 1);
  localparam logic [3:0]            BLANK_LAST = 4'(BLANK_TICKS - 1);
  localparam logic [2:0]            SEL_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{1'b1}};
  // With no blank gap a finished slot goes straight to the next lit digit.
  localparam state_t                SLOT_END   = (BLANK_TICKS == 0) ? ON : BLANK;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [2:0]            sel_n;
  logic                  src_n;
  logic                  fs_n;
  logic                  blink_phase, phase_n;
  logic [NUM_DIGITS-1:0] an_n;

  // Next-state, counter, digit index and anode pattern for the coming clock.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    src_n   = src_alarm;
    fs_n    = 1'b0;
    phase_n = blink_phase ^ blink_toggle;
    an_n    = AN_OFF;

    if (!enable) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      sel_n   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SLOT_END;
          cnt_n   = 4'd0;
          sel_n   = 3'd0;
          src_n   = show_alarm;
          fs_n    = (SLOT_END == ON);
        end
        BLANK: begin
          if (tick) begin
            if (cnt == BLANK_LAST) begin
              state_n = ON;
              cnt_n   = 4'd0;
              fs_n    = (sel == 3'd0);
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end else begin
            cnt_n = cnt;
          end
        end
        ON: begin
          if (tick) begin
            if (cnt == ON_LAST) begin
              state_n = SLOT_END;
              cnt_n   = 4'd0;
              // Source only switches on the wrap so a frame never mixes time and alarm.
              if (sel == SEL_LAST) begin
                sel_n = 3'd0;
                src_n = show_alarm;
                fs_n  = (SLOT_END == ON);
              end else begin
                sel_n = sel + 3'd1;
              end
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end else begin
            cnt_n = cnt;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
          sel_n   = 3'd0;
        end
      endcase
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_n[i] = ~((state_n == ON) && (sel_n == 3'(i)) && !(blink_mask[i] && phase_n));
    end
  end

  // State and output registers; anodes are derived from next state so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sel         <= 3'd0;
      an          <= AN_OFF;
      src_alarm   <= 1'b0;
      frame_start <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sel         <= sel_n;
      an          <= an_n;
      src_alarm   <= src_n;
      frame_start <= fs_n;
      blink_phase <= phase_n;
    end
  end

endmodule

// File: tb/tb_display_scan_sched.sv
// Directed bench for display_scan_sched: an arithmetic position model feeds a scoreboard queue
// that is popped and compared one clock after each stimulus step.
module tb_display_scan_sched;

  logic       clk = 1'b0;
  logic       rst, tick, enable, show_alarm, blink_toggle;
  logic [5:0] blink_mask;
  logic [2:0] sel;
  logic [5:0] an;
  logic       src_alarm, frame_start;

  logic       rst1, tick1, enable1, show_alarm1, blink_toggle1;
  logic [5:0] blink_mask1;
  logic [2:0] sel1;
  logic [5:0] an1;
  logic       src_alarm1, frame_start1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] sel;
    logic [5:0] an;
    logic       src;
    logic       fs;
  } exp_t;
  exp_t q[$];

  int   t;
  logic in_scan, src_m, phase_m, fs_m;

  display_scan_sched dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .show_alarm(show_alarm),
    .blink_mask(blink_mask), .blink_toggle(blink_toggle), .sel(sel), .an(an),
    .src_alarm(src_alarm), .frame_start(frame_start)
  );

  display_scan_sched #(.NUM_DIGITS(6), .ON_TICKS(1), .BLANK_TICKS(0)) dut_nogap (
    .clk(clk), .rst(rst1), .tick(tick1), .enable(enable1), .show_alarm(show_alarm1),
    .blink_mask(blink_mask1), .blink_toggle(blink_toggle1), .sel(sel1), .an(an1),
    .src_alarm(src_alarm1), .frame_start(frame_start1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare(input string tag, input logic [2:0] s, input logic [5:0] a,
                         input logic sa, input logic fs);
    exp_t g;
    g = q.pop_front();
    chk({tag, ".sel"}, 8'(s), 8'(g.sel));
    chk({tag, ".an"}, 8'(a), 8'(g.an));
    chk({tag, ".src_alarm"}, 8'(sa), 8'(g.src));
    chk({tag, ".frame_start"}, 8'(fs), 8'(g.fs));
    chk({tag, ".onecold"}, 8'((a == 6'h3f) || $onehot(~a)), 8'd1);
  endtask

  // One clock: drive at negedge, predict from tick position within the 30-tick frame.
  task automatic cyc(input logic tk, input logic bt);
    exp_t e;
    int   pos, d, r;
    tick         = tk;
    blink_toggle = bt;
    fs_m         = 1'b0;
    if (!enable) begin
      in_scan = 1'b0;
      t       = 0;
    end else if (!in_scan) begin
      in_scan = 1'b1;
      t       = 0;
      src_m   = show_alarm;
    end else if (tk) begin
      t++;
      if (t % 30 == 0) src_m = show_alarm;
      if (t % 30 == 1) fs_m = 1'b1;
    end
    if (bt) phase_m = ~phase_m;
    pos   = t % 30;
    d     = pos / 5;
    r     = pos % 5;
    e.sel = in_scan ? 3'(d) : 3'd0;
    e.an  = 6'h3f;
    if (in_scan && r != 0 && !(blink_mask[d] && phase_m)) e.an[d] = 1'b0;
    e.src = src_m;
    e.fs  = fs_m;
    q.push_back(e);
    @(posedge clk);
    #1;
    compare("scan", sel, an, src_alarm, frame_start);
    @(negedge clk);
    tick         = 1'b0;
    blink_toggle = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
    end
  endtask

  task automatic tick_until(input int target, input int minimum);
    int n = 0;
    while (!((t % 30) == target && t >= minimum) && n < 100) begin
      ticks(1);
      n++;
    end
    chk("tick_until.bound", 8'(n < 100), 8'd1);
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; tick = 1'b0; enable = 1'b0; show_alarm = 1'b0;
    blink_toggle = 1'b0; blink_mask = 6'b0;
    rst1 = 1'b0; tick1 = 1'b0; enable1 = 1'b0; show_alarm1 = 1'b0;
    blink_toggle1 = 1'b0; blink_mask1 = 6'b0;
    t = 0; in_scan = 1'b0; src_m = 1'b0; phase_m = 1'b0;

    #12;
    chk("reset.sel", 8'(sel), 8'd0);
    chk("reset.an", 8'(an), 8'h3f);
    chk("reset.src_alarm", 8'(src_alarm), 8'd0);
    chk("reset.frame_start", 8'(frame_start), 8'd0);
    chk("reset1.an", 8'(an1), 8'h3f);
    @(negedge clk);
    rst  = 1'b1;
    rst1 = 1'b1;

    // Idle: ticks ignored, blink phase still toggles and is restored.
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);

    enable = 1'b1;
    cyc(1'b0, 1'b0);
    ticks(60);

    // Alarm request mid-frame lands only at the wrap.
    tick_until(12, 60);
    show_alarm = 1'b1;
    tick_until(2, 90);
    chk("alarm.after_wrap", 8'(src_alarm), 8'd1);

    blink_mask = 6'b000011;
    cyc(1'b0, 1'b1);
    ticks(30);
    cyc(1'b0, 1'b1);
    ticks(30);

    // Disable coincident with a tick while digit 3 is lit.
    tick_until(17, 0);
    chk("drop.pre_sel", 8'(sel), 8'd3);
    enable = 1'b0;
    cyc(1'b1, 1'b0);
    chk("drop.sel", 8'(sel), 8'd0);
    chk("drop.an", 8'(an), 8'h3f);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    show_alarm = 1'b0;
    enable     = 1'b1;
    cyc(1'b0, 1'b0);
    chk("reenable.src_alarm", 8'(src_alarm), 8'd0);
    ticks(10);
    show_alarm = 1'b1;
    tick_until(5, 35);
    chk("preblank.src_alarm", 8'(src_alarm), 8'd1);

    // Asynchronous reset between edges during a blank slot.
    #2;
    rst = 1'b0;
    #1;
    chk("async.sel", 8'(sel), 8'd0);
    chk("async.an", 8'(an), 8'h3f);
    chk("async.src_alarm", 8'(src_alarm), 8'd0);
    chk("async.frame_start", 8'(frame_start), 8'd0);
    @(negedge clk);
    rst     = 1'b1;
    in_scan = 1'b0;
    t       = 0;
    src_m   = 1'b0;
    phase_m = 1'b0;
    cyc(1'b0, 1'b0);
    ticks(8);

    // No blank gap, one tick per digit, tick held high.
    enable1 = 1'b1;
    tick1   = 1'b1;
    for (int k = 0; k < 14; k++) begin
      e.sel = 3'(k % 6);
      e.an  = 6'h3f;
      e.an[k % 6] = 1'b0;
      e.src = 1'b0;
      e.fs  = (k % 6 == 0);
      q.push_back(e);
      @(posedge clk);
      #1;
      compare("nogap", sel1, an1, src_alarm1, frame_start1);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
